// File: rtl/ex_multiplier.sv
// Purpose : iterative radix-2 shift-add multiplier (MUL / SMULH / UMULH) for the EX stage.
// Latency : done pulses DATA_WIDTH+2 cycles after the start cycle; result holds until the next completion.
// Backpressure: start is only sampled in IDLE; busy stays high until DONE returns to IDLE; flush aborts.
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   start, op, a, b    request, operation select and operands (captured when start is accepted)
//   flush              synchronous abort; wins over start
//   busy, done, result busy while not IDLE, one-cycle completion pulse, registered product half
module ex_multiplier #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SMULH = 2'b01;
    localparam logic [1:0] OP_UMULH = 2'b10;

    localparam logic [DW-1:0]   ONE_D  = DW'(1);
    localparam logic [2*DW-1:0] ONE_2D = (2*DW)'(1);
    localparam logic [CW-1:0]   LAST   = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      op_q;
    logic [DW-1:0]   mcand;
    logic [DW-1:0]   mplier;
    logic            sign;
    logic [2*DW-1:0] acc;
    logic [CW-1:0]   cnt;

    logic            start_ok;
    logic            is_smulh;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;
    logic [DW:0]     sum;
    logic [2*DW-1:0] acc_shift;
    logic [2*DW-1:0] acc_fix;

    assign start_ok = start && !flush;
    assign is_smulh = (op == OP_SMULH);

    // Magnitudes are taken as DW-bit unsigned, so the most-negative value maps to 2^(DW-1) exactly.
    assign a_mag = (is_smulh && a[DW-1]) ? (~a + ONE_D) : a;
    assign b_mag = (is_smulh && b[DW-1]) ? (~b + ONE_D) : b;

    // Add into the upper half with a carry bit, then shift {carry, acc} right by one.
    assign sum       = {1'b0, acc[2*DW-1:DW]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_shift = {sum, acc[DW-1:1]};
    assign acc_fix   = sign ? (~acc + ONE_2D) : acc;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        op_q   <= op;
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        sign   <= is_smulh && (a[DW-1] ^ b[DW-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_shift;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    // An abort here must leave the previous result untouched.
                    if (!flush) begin
                        case (op_q)
                            OP_MUL:   result <= acc_fix[DW-1:0];
                            OP_SMULH: result <= acc_fix[2*DW-1:DW];
                            OP_UMULH: result <= acc_fix[2*DW-1:DW];
                            default:  result <= '0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_multiplier.sv
module tb_ex_multiplier;

    localparam int DW  = 64;
    localparam int LAT = DW + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    ex_multiplier #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product halves straight from wide arithmetic.
    function automatic logic [DW-1:0] ref_fn(input logic [1:0] o, input logic [DW-1:0] x,
                                             input logic [DW-1:0] y);
        logic [2*DW-1:0]        pu;
        logic signed [2*DW-1:0] ps;
        pu = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        ps = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
        case (o)
            2'b00:   return pu[DW-1:0];
            2'b01:   return ps[2*DW-1:DW];
            2'b10:   return pu[2*DW-1:DW];
            default: return '0;
        endcase
    endfunction

    // Timeline model: phase counts cycles since acceptance; done in cycle LAT.
    int            phase;
    logic [DW-1:0] m_pend;
    logic [DW-1:0] m_result;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= 0;
            m_pend   <= '0;
            m_result <= '0;
        end else if (flush) begin
            phase <= 0;
        end else if (phase == 0) begin
            if (start) begin
                phase  <= 1;
                m_pend <= ref_fn(op, a, b);
            end
        end else if (phase == LAT) begin
            phase <= 0;
        end else begin
            if (phase == LAT - 1) m_result <= m_pend;
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", DW'(busy), DW'(phase != 0));
            check("done", DW'(done), DW'(phase == LAT));
            check("result", result, m_result);
        end
    end

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(DW-1){1'b0}}};
            3:       return DW'($urandom_range(0, 20));
            4:       return -DW'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input bit noise, output logic [DW-1:0] res, output int lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
        end while (!done && lat < 200);
        start = 1'b0;
        res   = result;
    endtask

    initial begin
        logic [DW-1:0] r;
        int            lat;
        int            pulses;

        repeat (3) @(negedge clk);
        check("rst_busy", DW'(busy), '0);
        check("rst_done", DW'(done), '0);
        check("rst_result", result, '0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);

        run_op(2'b00, 64'd7, 64'd6, 1'b0, r, lat);
        check("mul_lat", DW'(lat), 64'd66);
        check("mul_7x6", r, 64'd42);
        @(negedge clk);
        check("done_one_cycle", DW'(done), '0);

        // Restart on the first IDLE cycle after done.
        run_op(2'b01, '1, 64'd1, 1'b0, r, lat);
        check("restart_lat", DW'(lat), 64'd66);
        check("smulh_m1x1", r, 64'hFFFF_FFFF_FFFF_FFFF);

        // start during DONE must be dropped.
        start = 1'b1;
        op    = 2'b00;
        a     = 64'd9;
        b     = 64'd9;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done", DW'(busy), '0);

        run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, r, lat);
        check("smulh_minxmin", r, 64'h4000_0000_0000_0000);
        @(negedge clk);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, lat);
        check("umulh_ffx2", r, 64'd1);
        @(negedge clk);
        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, lat);
        check("mul_ffx2", r, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        run_op(2'b11, 64'd123, 64'd456, 1'b0, r, lat);
        check("rsvd_lat", DW'(lat), 64'd66);
        check("rsvd_res", r, '0);
        @(negedge clk);

        // Starts and operand churn while busy must not disturb the first operation.
        run_op(2'b00, 64'd3, 64'd4, 1'b1, r, lat);
        check("busy_ignore_lat", DW'(lat), 64'd66);
        check("busy_ignore_res", r, 64'd12);
        @(negedge clk);

        // Flush at cycle 10 of a 3*5 multiply.
        start = 1'b1;
        op    = 2'b00;
        a     = 64'd3;
        b     = 64'd5;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", DW'(busy), '0);
        check("flush_result", result, 64'd12);
        pulses = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("flush_no_done", DW'(pulses), '0);

        // start and flush together: request dropped.
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_idle", DW'(busy), '0);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1;
        op    = 2'b01;
        a     = 64'd5;
        b     = 64'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_busy", DW'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", DW'(busy), '0);
        check("async_rst_done", DW'(done), '0);
        check("async_rst_result", result, '0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_no_done", DW'(pulses), '0);

        // Randomized traffic against the model.
        repeat (4000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 149) == 0);
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
